// File: rtl/mem_port_arbiter.sv
// Two-port arbiter that shares one memory between the CPU and a DMA/loader port.
// Define MEM_ARB_CPU_PRIO_EN for strict CPU priority; the default build is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;
  logic              owner_q;
`ifndef MEM_ARB_CPU_PRIO_EN
  logic              last_owner_q;
`endif

  logic              grant_s;
  logic              grant_dma_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Arbitration: decide whether anyone is granted this IDLE cycle and which port wins.
  always_comb begin
    grant_s = cpu_req | dma_req;
`ifdef MEM_ARB_CPU_PRIO_EN
    grant_dma_s = dma_req & ~cpu_req;
`else
    if (cpu_req && dma_req) begin
      grant_dma_s = ~last_owner_q;
    end else begin
      grant_dma_s = dma_req;
    end
`endif
  end

  // Request fields of the winning port, latched at grant.
  always_comb begin
    if (grant_dma_s) begin
      sel_we_s    = dma_we;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  // Access FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      cpu_rdata_q  <= {DATA_W{1'b0}};
      dma_rdata_q  <= {DATA_W{1'b0}};
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
`ifndef MEM_ARB_CPU_PRIO_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_s) begin
            state_q      <= S_ACCESS;
            cnt_q        <= CNT_LOAD;
            we_q         <= sel_we_s;
            addr_q       <= sel_addr_s;
            wdata_q      <= sel_wdata_s;
            mem_read_q   <= ~sel_we_s;
            mem_write_q  <= sel_we_s;
            busy_q       <= 1'b1;
            owner_q      <= grant_dma_s;
`ifndef MEM_ARB_CPU_PRIO_EN
            last_owner_q <= grant_dma_s;
`endif
          end
        end
        S_ACCESS: begin
          if (cnt_q == CNT_ZERO) begin
            state_q     <= S_ACK;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q) begin
              dma_ack_q <= 1'b1;
              if (!we_q) dma_rdata_q <= mem_rdata;
            end else begin
              cpu_ack_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_ACK: begin
          state_q   <= S_IDLE;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          cpu_ack_q   <= 1'b0;
          dma_ack_q   <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
